// File: rtl/dip_tick_gen_pkg.sv
// Shared widths and default timing constants for the DIP front-end, the
// rotator and the board top.
package dip_tick_gen_pkg;

    localparam int unsigned DEB_W = 20;
    localparam int unsigned TC_W  = 24;

    // 20 ms @ 50 MHz
    localparam int unsigned DEB_COUNT_DEF = 1000000;
    // 2^22 and 2^24 CLK cycles per TICK
    localparam int unsigned FAST_DIV_DEF  = 4194304;
    localparam int unsigned SLOW_DIV_DEF  = 16777216;

    typedef logic [DEB_W-1:0] dc_t;
    typedef logic [TC_W-1:0]  tc_t;
    typedef logic [1:0]       dip_t;

    // Terminal tick count for a divider; a divider of 2^24 still has a
    // terminal value that fits the 24-bit counter.
    function automatic tc_t period_last(input int unsigned div);
        int unsigned last;
        last = div - 1;
        return tc_t'(last);
    endfunction

    // Terminal debounce count; DEB_COUNT of 2^20 still fits 20 bits.
    function automatic dc_t deb_last(input int unsigned cnt);
        int unsigned last;
        last = cnt - 1;
        return dc_t'(last);
    endfunction

endpackage

// File: rtl/dip_tick_gen_if.sv
// Switch/tick bundle between the board pins, the DIP front-end and the rotator.
interface dip_tick_gen_if;
    import dip_tick_gen_pkg::*;

    dip_t DIP_IN;   // raw asynchronous switches
    dip_t DIP_OUT;  // debounced switch state
    dip_t DIP_CHG;  // one-cycle change strobe per bit
    logic DIR;      // rotate direction (0: left, 1: right)
    logic TICK;     // one-cycle rate enable

    // Board / test side: drives the switches, observes the front-end.
    modport master (
        output DIP_IN,
        input  DIP_OUT,
        input  DIP_CHG,
        input  DIR,
        input  TICK
    );

    // Front-end side.
    modport slave (
        input  DIP_IN,
        output DIP_OUT,
        output DIP_CHG,
        output DIR,
        output TICK
    );

endinterface

// File: rtl/dip_tick_gen_debounce_bit.sv
// One DIP switch: 2-flop synchroniser followed by a restart-on-glitch
// debounce counter. A change is accepted only after DEB_COUNT consecutive
// synchronised samples that differ from the current debounced value.
module dip_tick_gen_debounce_bit
    import dip_tick_gen_pkg::*;
#(
    parameter int unsigned DEB_COUNT = DEB_COUNT_DEF
) (
    input  logic CLK,
    input  logic RESET,
    input  logic din_i,
    output logic dout_o,
    output logic chg_o,
    output logic accept_o
);

    localparam dc_t DC_LAST = deb_last(DEB_COUNT);

    logic s1_q;
    logic s2_q;
    logic dout_q;
    logic dout_d;
    logic chg_q;
    logic chg_d;
    dc_t  dc_q;
    dc_t  dc_d;

    // Bring the raw switch into the CLK domain.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= din_i;
            s2_q <= s1_q;
        end
    end

    // Count consecutive disagreeing samples; any agreeing sample restarts.
    always_comb begin
        dout_d = dout_q;
        chg_d  = 1'b0;
        dc_d   = dc_q;
        if (s2_q == dout_q) begin
            dc_d = '0;
        end else if (dc_q == DC_LAST) begin
            dout_d = s2_q;
            chg_d  = 1'b1;
            dc_d   = '0;
        end else begin
            dc_d = dc_q + dc_t'(1);
        end
    end

    // Debounced state, change strobe and counter registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            dout_q <= 1'b0;
            chg_q  <= 1'b0;
            dc_q   <= '0;
        end else begin
            dout_q <= dout_d;
            chg_q  <= chg_d;
            dc_q   <= dc_d;
        end
    end

    assign dout_o   = dout_q;
    assign chg_o    = chg_q;
    // Asserted in the cycle whose edge registers the change, so the tick
    // counter can restart on the same edge that DIP_CHG rises.
    assign accept_o = chg_d;

endmodule

// File: rtl/dip_tick_gen.sv
// DIP front-end for the LED rotator: debounces both switches and produces a
// single-cycle TICK every FAST_DIV or SLOW_DIV cycles, selected by the
// debounced DIP[0]. A rate change restarts the period so no short or double
// ticks can reach the rotator.
module dip_tick_gen
    import dip_tick_gen_pkg::*;
#(
    parameter int unsigned DEB_COUNT = DEB_COUNT_DEF,
    parameter int unsigned FAST_DIV  = FAST_DIV_DEF,
    parameter int unsigned SLOW_DIV  = SLOW_DIV_DEF
) (
    input  logic           CLK,
    input  logic           RESET,
    dip_tick_gen_if.slave  bus
);

    localparam tc_t FAST_LAST = period_last(FAST_DIV);
    localparam tc_t SLOW_LAST = period_last(SLOW_DIV);

    dip_t dip_out;
    dip_t dip_chg;
    dip_t accept;
    tc_t  tc_q;
    tc_t  tc_d;
    tc_t  tc_term;
    logic tick_q;
    logic tick_d;

    dip_tick_gen_debounce_bit #(
        .DEB_COUNT (DEB_COUNT)
    ) u_deb0 (
        .CLK      (CLK),
        .RESET    (RESET),
        .din_i    (bus.DIP_IN[0]),
        .dout_o   (dip_out[0]),
        .chg_o    (dip_chg[0]),
        .accept_o (accept[0])
    );

    dip_tick_gen_debounce_bit #(
        .DEB_COUNT (DEB_COUNT)
    ) u_deb1 (
        .CLK      (CLK),
        .RESET    (RESET),
        .din_i    (bus.DIP_IN[1]),
        .dout_o   (dip_out[1]),
        .chg_o    (dip_chg[1]),
        .accept_o (accept[1])
    );

    // Select the terminal count for the currently debounced rate.
    always_comb begin
        tc_term = dip_out[0] ? SLOW_LAST : FAST_LAST;
    end

    // Period counter: a rate change wins over the terminal count so the new
    // rate always starts with a full period.
    always_comb begin
        tc_d   = tc_q + tc_t'(1);
        tick_d = 1'b0;
        if (accept[0]) begin
            tc_d   = '0;
            tick_d = 1'b0;
        end else if (tc_q == tc_term) begin
            tc_d   = '0;
            tick_d = 1'b1;
        end
    end

    // Tick counter and registered tick output.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            tc_q   <= '0;
            tick_q <= 1'b0;
        end else begin
            tc_q   <= tc_d;
            tick_q <= tick_d;
        end
    end

    assign bus.DIP_OUT = dip_out;
    assign bus.DIP_CHG = dip_chg;
    assign bus.DIR     = dip_out[1];
    assign bus.TICK    = tick_q;

endmodule

// File: tb/tb_dip_tick_gen.sv
// Self-checking bench for dip_tick_gen with small dividers.
module tb_dip_tick_gen;

    localparam int unsigned DEB  = 4;
    localparam int unsigned FAST = 8;
    localparam int unsigned SLOW = 32;

    logic CLK;
    logic RESET;
    int   checks;
    int   passed;

    dip_tick_gen_if bus_if ();

    dip_tick_gen #(
        .DEB_COUNT (DEB),
        .FAST_DIV  (FAST),
        .SLOW_DIV  (SLOW)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus_if)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    // Edges are numbered from reset release. A switch bit flips at edge n when
    // the synchronised samples of the last DEB edges all disagree with it and
    // no earlier flip (or reset) lies inside that window. A tick occurs when a
    // full period has elapsed since the last anchor (reset, tick, rate flip).
    int unsigned n;
    int unsigned anchor;
    int unsigned last_flip [2];
    int unsigned m_period;
    logic [1:0]  raw_hist [$];
    logic [1:0]  m_out;
    logic [1:0]  m_chg;
    logic [1:0]  m_flip;
    logic [1:0]  m_s;
    logic        m_tick;

    function automatic logic [1:0] synced_at(input int unsigned k);
        if (k >= 3) return raw_hist[k-3];
        return 2'b00;
    endfunction

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            n = 0;
            anchor = 0;
            last_flip[0] = 0;
            last_flip[1] = 0;
            raw_hist.delete();
            m_out = 2'b00;
            m_chg = 2'b00;
            m_tick = 1'b0;
        end else begin
            n++;
            raw_hist.push_back(bus_if.DIP_IN);
            m_flip = 2'b00;
            for (int b = 0; b < 2; b++) begin
                if (n - last_flip[b] >= DEB) begin
                    m_flip[b] = 1'b1;
                    for (int unsigned k = n - DEB + 1; k <= n; k++) begin
                        m_s = synced_at(k);
                        if (m_s[b] == m_out[b]) m_flip[b] = 1'b0;
                    end
                end
            end
            m_period = m_out[0] ? SLOW : FAST;
            if (m_flip[0]) begin
                anchor = n;
                m_tick = 1'b0;
            end else if (n - anchor == m_period) begin
                anchor = n;
                m_tick = 1'b1;
            end else begin
                m_tick = 1'b0;
            end
            m_chg = m_flip;
            m_out = m_out ^ m_flip;
            for (int b = 0; b < 2; b++)
                if (m_flip[b]) last_flip[b] = n;
        end
    end

    // Observation vectors: {DIP_OUT, DIP_CHG, DIR, TICK}
    function automatic logic [5:0] dut_vec();
        return {bus_if.DIP_OUT, bus_if.DIP_CHG, bus_if.DIR, bus_if.TICK};
    endfunction

    function automatic logic [5:0] model_vec();
        return {m_out, m_chg, m_out[1], m_tick};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [5:0] want;
        RESET = 1'b0;
        bus_if.DIP_IN = 2'b00;
        step();
        step();
        checks++;
        if (dut_vec() !== 6'b0)
            $display("FAIL reset_hold got %b expected %b", dut_vec(), 6'b0);
        else passed++;
        RESET = 1'b1;
        repeat (26) begin
            step();
            checks++;
            if (dut_vec() !== model_vec())
                $display("FAIL reset_model n=%0d got %b expected %b", n, dut_vec(), model_vec());
            else passed++;
            want = {4'b0000, 1'b0, (n % FAST) == 0};
            checks++;
            if (dut_vec() !== want)
                $display("FAIL reset_ticks n=%0d got %b expected %b", n, dut_vec(), want);
            else passed++;
        end
    endtask

    task automatic test_rate_switch();
        int unsigned f;
        logic        tk;
        logic [5:0]  want;
        step();
        bus_if.DIP_IN = 2'b01;
        f = n + DEB + 2;
        while (n < f + 70) begin
            step();
            checks++;
            if (dut_vec() !== model_vec())
                $display("FAIL rate_model n=%0d got %b expected %b", n, dut_vec(), model_vec());
            else passed++;
            tk = (n < f && (n % FAST) == 0) || (n > f && ((n - f) % SLOW) == 0);
            want = {1'b0, n >= f, 1'b0, n == f, 1'b0, tk};
            checks++;
            if (dut_vec() !== want)
                $display("FAIL rate_switch n=%0d got %b expected %b", n, dut_vec(), want);
            else passed++;
        end
    endtask

    task automatic test_glitch();
        int unsigned f;
        bus_if.DIP_IN = 2'b11;
        repeat (3) step();
        bus_if.DIP_IN = 2'b01;
        repeat (10) begin
            step();
            checks++;
            if (dut_vec() !== model_vec())
                $display("FAIL glitch_model n=%0d got %b expected %b", n, dut_vec(), model_vec());
            else passed++;
            checks++;
            if ({bus_if.DIP_OUT, bus_if.DIP_CHG, bus_if.DIR} !== 5'b01_00_0)
                $display("FAIL glitch_reject n=%0d got %b expected %b",
                         n, {bus_if.DIP_OUT, bus_if.DIP_CHG, bus_if.DIR}, 5'b01_00_0);
            else passed++;
        end
        bus_if.DIP_IN = 2'b11;
        f = n + DEB + 2;
        repeat (12) begin
            step();
            checks++;
            if (dut_vec() !== model_vec())
                $display("FAIL dir_model n=%0d got %b expected %b", n, dut_vec(), model_vec());
            else passed++;
            checks++;
            if ({bus_if.DIR, bus_if.DIP_CHG} !== {n >= f, n == f, 1'b0})
                $display("FAIL dir_update n=%0d got %b expected %b",
                         n, {bus_if.DIR, bus_if.DIP_CHG}, {n >= f, n == f, 1'b0});
            else passed++;
        end
    endtask

    task automatic test_coincide();
        int unsigned f;
        int unsigned g;
        logic        tk;
        bus_if.DIP_IN = 2'b10;
        f = n + DEB + 2;
        while (n < f + 10) begin
            step();
            checks++;
            if (dut_vec() !== model_vec())
                $display("FAIL coin_model n=%0d got %b expected %b", n, dut_vec(), model_vec());
            else passed++;
        end
        // change lands on the edge where fast tc would reach its terminal count
        bus_if.DIP_IN = 2'b11;
        g = f + 2 * FAST;
        while (n < g + 40) begin
            step();
            checks++;
            if (dut_vec() !== model_vec())
                $display("FAIL coin_model n=%0d got %b expected %b", n, dut_vec(), model_vec());
            else passed++;
            tk = (n == f + FAST) || (n == g + SLOW);
            checks++;
            if (bus_if.TICK !== tk)
                $display("FAIL coin_tick n=%0d got %b expected %b", n, bus_if.TICK, tk);
            else passed++;
            if (n == g) begin
                checks++;
                if (bus_if.DIP_CHG !== 2'b01)
                    $display("FAIL coin_chg n=%0d got %b expected %b", n, bus_if.DIP_CHG, 2'b01);
                else passed++;
            end
        end
    endtask

    task automatic test_reset_mid();
        bus_if.DIP_IN = 2'b00;
        repeat (4) begin
            step();
            checks++;
            if (dut_vec() !== model_vec())
                $display("FAIL mid_model n=%0d got %b expected %b", n, dut_vec(), model_vec());
            else passed++;
        end
        #3;
        RESET = 1'b0;
        #1;
        checks++;
        if (dut_vec() !== 6'b0)
            $display("FAIL mid_reset got %b expected %b", dut_vec(), 6'b0);
        else passed++;
        checks++;
        if (dut_vec() !== model_vec())
            $display("FAIL mid_reset_model got %b expected %b", dut_vec(), model_vec());
        else passed++;
        test_reset();
    endtask

    task automatic test_toggle();
        int unsigned f0;
        int unsigned last;
        int unsigned sp;
        bit          have;
        have = 1'b0;
        last = 0;
        f0 = n + DEB + 2;
        for (int i = 0; i < 240; i++) begin
            if (i < 200 && (i % 20) == 0) bus_if.DIP_IN[0] = ~bus_if.DIP_IN[0];
            step();
            checks++;
            if (dut_vec() !== model_vec())
                $display("FAIL toggle_model n=%0d got %b expected %b", n, dut_vec(), model_vec());
            else passed++;
            if (bus_if.TICK === 1'b1 && n > f0) begin
                if (have) begin
                    sp = n - last;
                    checks++;
                    if (sp != FAST && sp != SLOW)
                        $display("FAIL toggle_spacing n=%0d got %0d expected %0d or %0d", n, sp, FAST, SLOW);
                    else passed++;
                end
                have = 1'b1;
                last = n;
            end
        end
    endtask

    task automatic test_random();
        int unsigned hold;
        for (int i = 0; i < 50; i++) begin
            bus_if.DIP_IN = 2'($urandom_range(0, 3));
            hold = $urandom_range(1, 9);
            repeat (hold) begin
                step();
                checks++;
                if (dut_vec() !== model_vec())
                    $display("FAIL random_model n=%0d got %b expected %b", n, dut_vec(), model_vec());
                else passed++;
            end
        end
    endtask

    initial begin
        checks = 0;
        passed = 0;
        RESET = 1'b0;
        bus_if.DIP_IN = 2'b00;
        test_reset();
        test_rate_switch();
        test_glitch();
        test_coincide();
        test_reset_mid();
        test_toggle();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
